// File: rtl/mb_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// mb_adder_ctrl_if
//
// Bundle of every handshake and data signal of the multi-byte add/subtract
// sequencer: two request ports, the result port, and the byte-wide link to the
// shared combinational 8-bit CLA.
//
// Signal groups (directions seen from the sequencer, i.e. the slave modport):
//   req0_* / req1_*  in : valid, a, b, sub        out: ready
//   res_*            in : ready                   out: valid, sum, cout, ovf, id
//   add_*            in : Y, Cout (from the CLA)  out: A, B, Cin (to the CLA)
//
// Modports:
//   slave  - used by mb_adder_ctrl itself.
//   master - the surrounding environment (requesters, consumer and CLA).
// -----------------------------------------------------------------------------
interface mb_adder_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  // Requester 0
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_sub;

  // Requester 1
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_sub;

  // Result port
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;
  logic         res_id;

  // Shared 8-bit CLA link
  logic [7:0]   add_A;
  logic [7:0]   add_B;
  logic         add_Cin;
  logic [7:0]   add_Y;
  logic         add_Cout;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sub,
    output req1_ready,
    output res_valid, res_sum, res_cout, res_ovf, res_id,
    input  res_ready,
    output add_A, add_B, add_Cin,
    input  add_Y, add_Cout
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sub,
    input  req1_ready,
    input  res_valid, res_sum, res_cout, res_ovf, res_id,
    output res_ready,
    input  add_A, add_B, add_Cin,
    output add_Y, add_Cout
  );

endinterface

// File: rtl/mb_adder_ctrl.sv
// -----------------------------------------------------------------------------
// mb_adder_ctrl
//
// Multi-byte add/subtract sequencer sharing one external combinational 8-bit
// CLA between two requesters. An operation is accepted from one requester
// (round-robin on ties), then the CLA is stepped one byte per cycle from LSB
// to MSB with the carry rippled through a register. The finished W-bit result
// is presented on a valid/ready port until the consumer takes it.
//
// Parameters:
//   NBYTES  operand width in bytes (2..16), W = 8*NBYTES.
//
// Ports:
//   clk  rising-edge clock.
//   rst  asynchronous, active-high reset.
//   bus  mb_adder_ctrl_if.slave: request ports 0/1, result port, CLA link.
//
// Flow: IDLE (grant + latch) -> RUN (NBYTES cycles) -> DONE (hold result)
// -> IDLE. Throughput is NBYTES+2 cycles per operation with res_ready high.
// -----------------------------------------------------------------------------
module mb_adder_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  mb_adder_ctrl_if.slave  bus
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = $clog2(NBYTES);

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;        // raw B; inversion for subtract applied per byte
  logic            sub_q, sub_d;
  logic            id_q, id_d;
  logic            last_q, last_d;  // requester that owned the last delivered result
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic [7:0]      sum_byte_q [NBYTES];
  logic [7:0]      a_byte     [NBYTES];
  logic [7:0]      b_byte     [NBYTES];  // already XORed with sub
  logic [W-1:0]    sum_flat;

  logic in_idle;
  logic in_run;
  logic in_done;
  logic grant0;
  logic grant1;
  logic accept;

  assign in_idle = (state_q == ST_IDLE);
  assign in_run  = (state_q == ST_RUN);
  assign in_done = (state_q == ST_DONE);

  // ---------------------------------------------------------------------------
  // Round-robin grant. On a tie the requester that did not own the last result
  // wins. Gated by rst so no ready pulse leaks out while held in reset.
  // ---------------------------------------------------------------------------
  assign grant0 = in_idle && !rst && bus.req0_valid && (!bus.req1_valid || last_q);
  assign grant1 = in_idle && !rst && bus.req1_valid && (!bus.req0_valid || !last_q);
  assign accept = grant0 || grant1;

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // ---------------------------------------------------------------------------
  // Byte views of the latched operands and the result accumulator
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign a_byte[gi]           = a_q[8*gi +: 8];
      assign b_byte[gi]           = b_q[8*gi +: 8] ^ {8{sub_q}};
      assign sum_flat[8*gi +: 8]  = sum_byte_q[gi];

      // Each result byte is written exactly once per operation, in the RUN
      // cycle whose index selects it, and otherwise holds.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_byte_q[gi] <= '0;
        end else if (in_run && (idx_q == IDXW'(gi))) begin
          sum_byte_q[gi] <= bus.add_Y;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    id_d    = id_q;
    last_d  = last_q;
    carry_d = carry_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = grant1 ? bus.req1_a   : bus.req0_a;
          b_d     = grant1 ? bus.req1_b   : bus.req0_b;
          sub_d   = grant1 ? bus.req1_sub : bus.req0_sub;
          id_d    = grant1;
          idx_d   = '0;
          // Subtract is A + ~B + 1: the +1 enters as the initial carry.
          carry_d = grant1 ? bus.req1_sub : bus.req0_sub;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        carry_d = bus.add_Cout;
        if (idx_q == IDX_LAST) begin
          // Explicit clear: for non-power-of-two NBYTES the increment would
          // not wrap back to 0 by itself.
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
        end
      end

      ST_DONE: begin
        if (bus.res_ready) begin
          last_d  = id_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;   // requester 0 wins the first tie
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      id_q    <= id_d;
      last_q  <= last_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // CLA drive: only meaningful in RUN, forced to zero elsewhere so the shared
  // adder sees quiet inputs between operations.
  // ---------------------------------------------------------------------------
  assign bus.add_A   = in_run ? a_byte[idx_q] : 8'd0;
  assign bus.add_B   = in_run ? b_byte[idx_q] : 8'd0;
  assign bus.add_Cin = in_run ? carry_q       : 1'b0;

  // ---------------------------------------------------------------------------
  // Result port. All fields come straight from registers that do not change
  // in DONE, so they hold until the handshake.
  // ---------------------------------------------------------------------------
  assign bus.res_valid = in_done;
  assign bus.res_sum   = sum_flat;
  assign bus.res_cout  = carry_q;
  assign bus.res_id    = id_q;
  // Signed overflow: operands (after subtract inversion) agree in sign but the
  // result sign differs from them.
  assign bus.res_ovf   = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (sum_flat[W-1] != a_q[W-1]);

endmodule
